// File: rtl/screen_cursor_ctrl_pkg.sv
// rtl/screen_cursor_ctrl_pkg.sv - shared constants and types for the character-screen cursor controller
package screen_cursor_ctrl_pkg;

  localparam int GLYPH_W  = 6;
  localparam int COLOUR_W = 3;
  localparam int DATA_W   = GLYPH_W + COLOUR_W;
  localparam int ADDR_W   = 9;
  localparam int X_W      = 5;
  localparam int Y_W      = 4;

  localparam logic [2:0] MV_NONE  = 3'b000;
  localparam logic [2:0] MV_LEFT  = 3'b001;
  localparam logic [2:0] MV_RIGHT = 3'b010;
  localparam logic [2:0] MV_DOWN  = 3'b011;
  localparam logic [2:0] MV_UP    = 3'b100;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CHAR_WR  = 2'd1;
  localparam logic [1:0] ST_CLEAR_WR = 2'd2;

  localparam logic [COLOUR_W-1:0] DEFAULT_COLOUR = 3'b111;

  typedef struct packed {
    logic [GLYPH_W-1:0]  glyph;
    logic [COLOUR_W-1:0] colour;
  } wr_data_t;

  function automatic logic is_move(input logic [2:0] code);
    return (code == MV_LEFT) || (code == MV_RIGHT) || (code == MV_DOWN) || (code == MV_UP);
  endfunction

endpackage

// File: rtl/screen_cursor_ctrl_if.sv
// rtl/screen_cursor_ctrl_if.sv - frame-buffer write port between controller and frame buffer
interface screen_cursor_ctrl_if;
  import screen_cursor_ctrl_pkg::*;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);

endinterface

// File: rtl/screen_cursor_ctrl_cursor_pos.sv
// rtl/screen_cursor_ctrl_cursor_pos.sv - cursor x/y register with wrap arithmetic and cell address
module cursor_pos
  import screen_cursor_ctrl_pkg::*;
#(
  parameter int COLS = 20,
  parameter int ROWS = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance_i,
  input  logic              home_i,
  input  logic              move_en_i,
  input  logic [2:0]        move_i,
  output logic [X_W-1:0]    x_o,
  output logic [Y_W-1:0]    y_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (home_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      // Text-style advance: end of row spills into the next row, last cell wraps home
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end else if (move_en_i) begin
      case (move_i)
        MV_LEFT:  x_d = (x_q == '0)     ? X_LAST : x_q - X_W'(1);
        MV_RIGHT: x_d = (x_q == X_LAST) ? '0     : x_q + X_W'(1);
        MV_UP:    y_d = (y_q == '0)     ? Y_LAST : y_q - Y_W'(1);
        MV_DOWN:  y_d = (y_q == Y_LAST) ? '0     : y_q + Y_W'(1);
        default: begin
          x_d = x_q;
          y_d = y_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = ADDR_W'(y_q) * ADDR_W'(COLS) + ADDR_W'(x_q);

endmodule

// File: rtl/screen_cursor_ctrl.sv
// rtl/screen_cursor_ctrl.sv - character-screen cursor controller issuing frame-buffer writes
module screen_cursor_ctrl
  import screen_cursor_ctrl_pkg::*;
#(
  parameter int         COLS        = 20,
  parameter int         ROWS        = 15,
  parameter logic [5:0] BLANK_GLYPH = 6'b111111
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 char_stb,
  input  logic [GLYPH_W-1:0]   glyph_in,
  input  logic                 r,
  input  logic                 g,
  input  logic                 b,
  input  logic                 f,
  input  logic [2:0]           up,
  screen_cursor_ctrl_if.master fb,
  output logic [X_W-1:0]       cursor_x,
  output logic [Y_W-1:0]       cursor_y,
  output logic [COLOUR_W-1:0]  colour,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  logic [1:0]          state_q, state_d;
  logic                wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  wr_data_t            wr_data_q, wr_data_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  logic              xfer_done;
  logic              advance;
  logic              home;
  logic              move_en;
  logic [ADDR_W-1:0] cur_addr;

  assign xfer_done = wr_req_q & fb.wr_ack;

  always_comb begin
    state_d   = state_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    colour_d  = colour_q ^ {r, g, b};
    advance   = 1'b0;
    home      = 1'b0;
    move_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Latched data uses the colour before this cycle's toggles
        if (f) begin
          state_d   = ST_CLEAR_WR;
          wr_req_d  = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '{glyph: BLANK_GLYPH, colour: colour_q};
        end else if (char_stb) begin
          state_d   = ST_CHAR_WR;
          wr_req_d  = 1'b1;
          wr_addr_d = cur_addr;
          wr_data_d = '{glyph: glyph_in, colour: colour_q};
        end else begin
          move_en = is_move(up);
        end
      end
      ST_CHAR_WR: begin
        if (xfer_done) begin
          state_d  = ST_IDLE;
          wr_req_d = 1'b0;
          advance  = 1'b1;
        end
      end
      ST_CLEAR_WR: begin
        if (xfer_done) begin
          if (wr_addr_q == LAST_ADDR) begin
            state_d  = ST_IDLE;
            wr_req_d = 1'b0;
            home     = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      colour_q  <= DEFAULT_COLOUR;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      colour_q  <= colour_d;
    end
  end

  cursor_pos #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor_pos (
    .clock     (clock),
    .reset     (reset),
    .advance_i (advance),
    .home_i    (home),
    .move_en_i (move_en),
    .move_i    (up),
    .x_o       (cursor_x),
    .y_o       (cursor_y),
    .addr_o    (cur_addr)
  );

  assign fb.wr_req  = wr_req_q;
  assign fb.wr_addr = wr_addr_q;
  assign fb.wr_data = wr_data_q;
  assign colour     = colour_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_screen_cursor_ctrl.sv
// tb/tb_screen_cursor_ctrl.sv - self-checking bench for screen_cursor_ctrl against a cell-index model
module tb_screen_cursor_ctrl;

  localparam int COLS = 20;
  localparam int ROWS = 15;
  localparam int N    = COLS * ROWS;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       char_stb = 1'b0;
  logic [5:0] glyph_in = '0;
  logic       r = 1'b0, g = 1'b0, b = 1'b0, f = 1'b0;
  logic [2:0] up = '0;
  logic [4:0] cursor_x;
  logic [3:0] cursor_y;
  logic [2:0] colour;
  logic       busy;

  screen_cursor_ctrl_if fb();

  screen_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK_GLYPH(6'b111111)) dut (
    .clock    (clock),
    .reset    (reset),
    .char_stb (char_stb),
    .glyph_in (glyph_in),
    .r        (r),
    .g        (g),
    .b        (b),
    .f        (f),
    .up       (up),
    .fb       (fb),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .colour   (colour),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: 0 idle, 1 char write pending, 2 clear in progress
  int         m_mode, m_x, m_y, m_idx, m_addr;
  logic [2:0] m_col;
  logic [8:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_idx = 0; m_addr = 0;
    m_col = 3'b111; m_data = '0;
  endtask

  task automatic model_step();
    int lin;
    bit ack;
    ack = (m_mode != 0) && fb.wr_ack;
    case (m_mode)
      0: begin
        if (f) begin
          m_mode = 2; m_idx = 0; m_data = {6'h3F, m_col};
        end else if (char_stb) begin
          m_mode = 1; m_addr = m_y * COLS + m_x; m_data = {glyph_in, m_col};
        end else begin
          case (up)
            3'b001: m_x = (m_x + COLS - 1) % COLS;
            3'b010: m_x = (m_x + 1) % COLS;
            3'b100: m_y = (m_y + ROWS - 1) % ROWS;
            3'b011: m_y = (m_y + 1) % ROWS;
            default: ;
          endcase
        end
      end
      1: if (ack) begin
        lin = (m_y * COLS + m_x + 1) % N;
        m_x = lin % COLS; m_y = lin / COLS; m_mode = 0;
      end
      default: if (ack) begin
        if (m_idx == N - 1) begin
          m_mode = 0; m_x = 0; m_y = 0;
        end else begin
          m_idx++;
        end
      end
    endcase
    m_col = m_col ^ {r, g, b};
  endtask

  task automatic compare_all();
    chk("busy", busy, m_mode != 0);
    chk("wr_req", fb.wr_req, m_mode != 0);
    chk("cursor_x", cursor_x, m_x);
    chk("cursor_y", cursor_y, m_y);
    chk("colour", colour, m_col);
    if (m_mode != 0) begin
      chk("wr_addr", fb.wr_addr, (m_mode == 1) ? m_addr : m_idx);
      chk("wr_data", fb.wr_data, m_data);
    end else if (!reset) begin
      chk("wr_addr_rst", fb.wr_addr, 0);
      chk("wr_data_rst", fb.wr_data, 0);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    if (!reset) model_reset();
    else model_step();
    @(negedge clock);
    compare_all();
    char_stb = 1'b0; r = 1'b0; g = 1'b0; b = 1'b0; f = 1'b0; up = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held, cnt, bad;
    fb.wr_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_wr_req", fb.wr_req, 0);
    chk("rst_wr_addr", fb.wr_addr, 0);
    chk("rst_wr_data", fb.wr_data, 0);
    chk("rst_cursor", {cursor_x, cursor_y}, 0);
    chk("rst_colour", colour, 3'b111);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    // first character write
    glyph_in = 6'h10; char_stb = 1'b1;
    cyc();
    chk("c1_busy", busy, 1);
    chk("c1_addr", fb.wr_addr, 0);
    chk("c1_data", fb.wr_data, 9'h087);
    fb.wr_ack = 1'b1;
    cyc();
    fb.wr_ack = 1'b0;
    chk("c1_done_busy", busy, 0);
    chk("c1_cursor", {cursor_x, cursor_y}, {5'd1, 4'd0});

    // move wrap cases
    up = 3'b001; cyc();
    repeat (3) begin up = 3'b011; cyc(); end
    up = 3'b001; cyc();
    chk("mv_left_wrap", {cursor_x, cursor_y}, {5'd19, 4'd3});
    repeat (6) begin up = 3'b010; cyc(); end
    repeat (3) begin up = 3'b100; cyc(); end
    up = 3'b100; cyc();
    chk("mv_up_wrap", {cursor_x, cursor_y}, {5'd5, 4'd14});
    up = 3'b111; cyc();
    chk("mv_none", {cursor_x, cursor_y}, {5'd5, 4'd14});
    repeat (6) begin up = 3'b001; cyc(); end

    // last cell with stalled ack
    glyph_in = 6'h2A; char_stb = 1'b1;
    cyc();
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (fb.wr_req && fb.wr_addr == 9'd299) held++;
      cyc();
    end
    if (fb.wr_req && fb.wr_addr == 9'd299) held++;
    fb.wr_ack = 1'b1;
    cyc();
    fb.wr_ack = 1'b0;
    chk("stall_held", held, 6);
    chk("last_wrap", {cursor_x, cursor_y}, 0);

    // clear beats char_stb; commands and colour toggles during clear
    f = 1'b1; char_stb = 1'b1; glyph_in = 6'h05; fb.wr_ack = 1'b1;
    cyc();
    cnt = 0; bad = 0;
    for (int k = 0; k < 400 && fb.wr_req; k++) begin
      if (fb.wr_addr !== 9'(cnt) || fb.wr_data !== 9'h1FF) bad++;
      cnt++;
      if (cnt == 10) begin r = 1'b1; char_stb = 1'b1; end
      cyc();
    end
    chk("clear_writes", cnt, 300);
    chk("clear_seq_bad", bad, 0);
    chk("clear_colour", colour, 3'b011);
    chk("clear_cursor", {cursor_x, cursor_y}, 0);
    chk("clear_idle", busy, 0);

    // reset during clear
    f = 1'b1;
    cyc();
    for (int k = 0; k < 200 && fb.wr_addr != 9'd100; k++) cyc();
    chk("clr_reach100", fb.wr_addr, 100);
    #2 reset = 1'b0;
    #1;
    chk("arst_wr_req", fb.wr_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", fb.wr_addr, 0);
    chk("arst_colour", colour, 3'b111);
    model_reset();
    cyc();
    reset = 1'b1;
    fb.wr_ack = 1'b0;

    // randomized traffic
    for (int it = 0; it < 4000; it++) begin
      fb.wr_ack = ($urandom % 3) != 0;
      char_stb  = ($urandom % 4) == 0;
      glyph_in  = 6'($urandom);
      up        = (($urandom % 2) == 0) ? 3'($urandom) : 3'b000;
      r = ($urandom % 8) == 0;
      g = ($urandom % 8) == 0;
      b = ($urandom % 8) == 0;
      f = ($urandom % 250) == 0;
      reset = ($urandom % 800) != 0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
